// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter from a fixed-latency synchronous FIFO to a valid/ready stream.
// Optional m_last burst marking is enabled with `define FIFO_RD_ADAPTER_LAST_EN.
module fifo_rd_stream_adapter #(
   parameter int unsigned c_DATA_WIDTH = 32,
   parameter int unsigned c_RD_LATENCY = 1,
   parameter int unsigned c_BUF_AW     = 2,
   parameter int unsigned c_BURST_LEN  = 256
) (
   input  logic                    rd_clk,
   input  logic                    rd_rst,
   output logic                    fifo_rd_en,
   input  logic                    fifo_rd_empty,
   input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [c_DATA_WIDTH-1:0] m_data,
`ifdef FIFO_RD_ADAPTER_LAST_EN
   output logic                    m_last,
`endif
   output logic [c_BUF_AW:0]       buf_level,
   output logic [31:0]             beat_cnt,
   input  logic                    cnt_clr
);

   localparam int unsigned DEPTH = 2 ** c_BUF_AW;
   localparam int unsigned LW    = c_BUF_AW + 1;
   localparam int unsigned CW    = c_BUF_AW + 2;
   localparam int unsigned BCW   = 16;

   if (c_RD_LATENCY < 1 || c_RD_LATENCY > 2 || DEPTH < c_RD_LATENCY + 1 ||
       c_BURST_LEN < 2 || c_BURST_LEN > 65536) begin : g_param_err
      $error("fifo_rd_stream_adapter: illegal parameter combination");
   end

   logic [c_RD_LATENCY-1:0] infl_q, infl_d;
   logic [c_DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [c_DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [c_BUF_AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic [31:0]             beat_cnt_q, beat_cnt_d;
   logic [CW-1:0]           credits_c;
   logic                    push_c, pop_c, rd_en_c;

   // Credits cover both stored words and words still travelling through the FIFO read pipe.
   always_comb begin
      credits_c = CW'(level_q);
      for (int i = 0; i < int'(c_RD_LATENCY); i++) begin
         credits_c = credits_c + CW'(infl_q[i]);
      end
   end

   assign rd_en_c    = !rd_rst && !fifo_rd_empty && (credits_c < CW'(DEPTH));
   assign push_c     = infl_q[c_RD_LATENCY-1];
   assign pop_c      = m_valid && m_ready;
   assign fifo_rd_en = rd_en_c;
   assign m_valid    = (level_q != '0);
   assign m_data     = mem_q[rptr_q];
   assign buf_level  = level_q;
   assign beat_cnt   = beat_cnt_q;

   always_comb begin
      infl_d     = infl_q;
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      level_d    = level_q;
      beat_cnt_d = beat_cnt_q;

      infl_d[0] = rd_en_c;
      for (int i = 1; i < int'(c_RD_LATENCY); i++) begin
         infl_d[i] = infl_q[i-1];
      end

      if (push_c) begin
         mem_d[wptr_q] = fifo_rd_data;
         wptr_d        = wptr_q + c_BUF_AW'(1);
      end
      if (pop_c) begin
         rptr_d = rptr_q + c_BUF_AW'(1);
      end
      level_d = level_q + LW'(push_c) - LW'(pop_c);

      if (cnt_clr) begin
         beat_cnt_d = '0;
      end else if (pop_c) begin
         beat_cnt_d = beat_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         infl_q     <= '0;
         mem_q      <= '{default: '0};
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         infl_q     <= infl_d;
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_RD_ADAPTER_LAST_EN
   localparam logic [BCW-1:0] BURST_END = BCW'(c_BURST_LEN - 1);

   logic [BCW-1:0] burst_q, burst_d;
   logic           burst_end_c;

   assign burst_end_c = (burst_q == BURST_END);
   assign m_last      = m_valid && burst_end_c;

   // Position within the current burst; restarts after the last beat is taken.
   always_comb begin
      burst_d = burst_q;
      if (cnt_clr) begin
         burst_d = '0;
      end else if (pop_c) begin
         burst_d = burst_end_c ? '0 : burst_q + BCW'(1);
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
      end
   end
`endif

`ifndef SYNTHESIS
   a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
      !(push_c && level_q == LW'(DEPTH)))
      else $error("fifo_rd_stream_adapter: push into full skid buffer");
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Scoreboard bench for fifo_rd_stream_adapter: a queue-based FIFO model with
// configurable read latency feeds the DUT; the monitor checks the stream output.
module tb_fifo_rd_stream_adapter;

   localparam int unsigned DW    = 32;
   localparam int unsigned LAT   = 2;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned BL    = 4;

   logic          rd_clk = 1'b0;
   logic          rd_rst = 1'b1;
   logic          fifo_rd_empty = 1'b1;
   logic          m_ready = 1'b0;
   logic          cnt_clr = 1'b0;
   logic          fifo_rd_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic [DW-1:0] fifo_rd_data;
   logic [AW:0]   buf_level;
   logic [31:0]   beat_cnt;
`ifdef FIFO_RD_ADAPTER_LAST_EN
   logic          m_last;
   int            bcnt = 0;
   int            last_count = 0;
`endif

   fifo_rd_stream_adapter #(
      .c_DATA_WIDTH(DW),
      .c_RD_LATENCY(LAT),
      .c_BUF_AW    (AW),
      .c_BURST_LEN (BL)
   ) dut (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_empty(fifo_rd_empty),
      .fifo_rd_data (fifo_rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
`ifdef FIFO_RD_ADAPTER_LAST_EN
      .m_last       (m_last),
`endif
      .buf_level    (buf_level),
      .beat_cnt     (beat_cnt),
      .cnt_clr      (cnt_clr)
   );

   always #5 rd_clk = ~rd_clk;

   logic [DW-1:0] fifo_q [$];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] dst [LAT];
   logic [DW-1:0] prev_data = '0;
   logic          prev_stall = 1'b0;
   logic          mon_en = 1'b0;

   int n_checks = 0, n_pass = 0;
   int cyc = 0, rd_cyc = 0, rd_count = 0;
   int beats = 0, valid_cycles = 0, first_beat_cyc = 0, last_beat_cyc = 0;
   int proto_err = 0, stall_err = 0, unexp_err = 0, max_level = 0;
   logic [31:0] exp_cnt = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   assign fifo_rd_data = dst[LAT-1];

   // FIFO model: pops on rd_en, data emerges LAT edges later; garbage otherwise.
   always @(posedge rd_clk) begin
      cyc++;
      if (mon_en) begin
         if (fifo_rd_en && fifo_rd_empty) proto_err++;
         if (int'(buf_level) > max_level) max_level = int'(buf_level);
      end
      if (fifo_rd_en) begin
         rd_count++;
         rd_cyc = cyc;
      end
      for (int i = LAT - 1; i > 0; i--) dst[i] <= dst[i-1];
      if (fifo_rd_en && fifo_q.size() > 0) dst[0] <= fifo_q.pop_front();
      else dst[0] <= $urandom;
      if (rd_rst) begin
         fifo_q.delete();
         exp_q.delete();
      end
   end

   // Stream monitor and reference model, evaluated mid-cycle.
   always @(negedge rd_clk) begin
      if (mon_en) begin
         check("beat_cnt", beat_cnt, exp_cnt);
         if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
`ifdef FIFO_RD_ADAPTER_LAST_EN
         check("m_last", 32'(m_last), 32'(m_valid && bcnt == int'(BL) - 1));
`endif
         if (rd_rst) begin
            exp_cnt    = '0;
            prev_stall = 1'b0;
`ifdef FIFO_RD_ADAPTER_LAST_EN
            bcnt = 0;
`endif
         end else begin
            if (m_valid) valid_cycles++;
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) unexp_err++;
               else check("data", m_data, exp_q.pop_front());
               if (beats == 0) first_beat_cyc = cyc;
               beats++;
               last_beat_cyc = cyc;
               exp_cnt = exp_cnt + 32'd1;
`ifdef FIFO_RD_ADAPTER_LAST_EN
               if (m_last) last_count++;
               bcnt = (bcnt == int'(BL) - 1) ? 0 : bcnt + 1;
`endif
            end
            if (cnt_clr) begin
               exp_cnt = '0;
`ifdef FIFO_RD_ADAPTER_LAST_EN
               bcnt = 0;
`endif
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
         end
      end
      fifo_rd_empty = (fifo_q.size() == 0);
   end

   task automatic step(input int n);
      repeat (n) @(posedge rd_clk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic clr_stats();
      beats = 0;
      valid_cycles = 0;
      rd_count = 0;
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int k = 0;
      m_ready = 1'b1;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || m_valid) && k < max_cyc) begin
         step(1);
         k++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic pulse_clr();
      cnt_clr = 1'b1;
      step(1);
      cnt_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < int'(LAT); i++) dst[i] = '0;
      step(3);
      @(negedge rd_clk);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", m_data, 32'd0);
      check("rst_buf_level", 32'(buf_level), 32'd0);
      check("rst_beat_cnt", beat_cnt, 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      mon_en = 1'b1;
      step(1);
      rd_rst = 1'b0;
      step(2);

      // Single word
      clr_stats();
      m_ready = 1'b1;
      push_word(32'hA5A5_0001);
      step(12);
      check("single_rd_pulses", 32'(rd_count), 32'd1);
      check("single_latency", 32'(first_beat_cyc - rd_cyc), 32'(LAT));
      check("single_valid_cycles", 32'(valid_cycles), 32'd1);
      check("single_beat_cnt", beat_cnt, 32'd1);

      // Streaming 1000 words, no back-pressure
      pulse_clr();
      clr_stats();
      for (int i = 0; i < 1000; i++) push_word(32'h0001_0000 + 32'(i));
      drain("stream_drain", 1500);
      check("stream_beats", 32'(beats), 32'd1000);
      check("stream_gapless", 32'(last_beat_cyc - first_beat_cyc + 1), 32'd1000);
      check("stream_beat_cnt", beat_cnt, 32'd1000);

      // Back-pressure
      clr_stats();
      m_ready = 1'b0;
      for (int i = 0; i < 20; i++) push_word(32'hB000_0000 + 32'(i));
      step(30);
      check("bp_level", 32'(buf_level), 32'(DEPTH));
      check("bp_reads", 32'(rd_count), 32'(DEPTH));
      check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
      check("bp_valid", 32'(m_valid), 32'd1);
      drain("bp_drain", 200);
      check("bp_beats", 32'(beats), 32'd20);
      check("bp_stall_stable", 32'(stall_err), 32'd0);

      // Random ready, intermittently empty FIFO, occasional counter clear
      for (int c = 0; c < 600; c++) begin
         m_ready = 1'($urandom_range(1, 0));
         cnt_clr = ($urandom_range(31, 0) == 0);
         if ($urandom_range(9, 0) < 4) push_word($urandom);
         step(1);
      end
      cnt_clr = 1'b0;
      drain("rand_drain", 300);
      check("rand_rd_en_while_empty", 32'(proto_err), 32'd0);
      check("rand_level_bound", 32'(max_level > int'(DEPTH)), 32'd0);
      check("rand_stall_stable", 32'(stall_err), 32'd0);
      check("rand_unexpected", 32'(unexp_err), 32'd0);

      // Reset with two reads in flight
      pulse_clr();
      clr_stats();
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(32'hC000_0000 + 32'(i));
      step(2);
      check("rstmid_reads", 32'(rd_count), 32'd2);
      rd_rst = 1'b1;
      step(1);
      rd_rst = 1'b0;
      valid_cycles = 0;
      @(negedge rd_clk);
      check("rstmid_m_valid", 32'(m_valid), 32'd0);
      check("rstmid_buf_level", 32'(buf_level), 32'd0);
      check("rstmid_beat_cnt", beat_cnt, 32'd0);
      m_ready = 1'b1;
      step(12);
      check("rstmid_no_late_data", 32'(valid_cycles), 32'd0);
      check("rstmid_unexpected", 32'(unexp_err), 32'd0);

`ifdef FIFO_RD_ADAPTER_LAST_EN
      // Burst marking over 8 beats
      pulse_clr();
      last_count = 0;
      for (int i = 0; i < 8; i++) push_word(32'hD000_0000 + 32'(i));
      drain("last_drain", 100);
      check("last_count", 32'(last_count), 32'd2);
`endif

      check("final_rd_en_while_empty", 32'(proto_err), 32'd0);
      check("final_unexpected", 32'(unexp_err), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
